osc_div_gen: RTL
================

OSC_DIV_GEN -- requirements
Module: osc_div_gen

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent divider channels (1..16) SHALL be supported.
REQ-002 Parameter DIV_W, default 16, SHALL set the divide-value width.
REQ-003 Parameter RST_DIV, default 3, SHALL set every channel's divide value after reset.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Ports SHALL be, in order:
- clk  in  1  oscillator clock
- rst_n  in  1  async active-low reset
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accept
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel
- cfg_div  in  DIV_W  new divide value
- cfg_en  in  1  channel enable
- sync_i  in  1  realign all channels
- tick_o  out  NUM_CH  one-cycle enable pulse per channel
- div_clk_o  out  NUM_CH  square-wave output per channel

Function
REQ-006 Each channel SHALL hold a counter 0..D-1, where D is its active divide value, and SHALL increment once per clk while enabled.
REQ-007 tick_o[n] SHALL be high for exactly one cycle when counter n equals D-1; the counter SHALL then wrap to 0 on the next cycle.
REQ-008 D=0 SHALL be treated as D=1. With D=1, tick_o[n] SHALL be high on every enabled cycle.
REQ-009 A config transfer SHALL occur on a cycle where cfg_valid && cfg_ready; cfg_div and cfg_en SHALL be captured into the shadow register of channel cfg_ch.
REQ-010 Channel state machine:
- OFF -> RUN: on a transfer with cfg_en=1; load D and counter=0 the next cycle.
- RUN -> PEND: on a transfer.
- PEND -> RUN or OFF: on the cycle the counter wraps (tick), apply the shadow; a running channel SHALL never produce a shortened or lengthened period.
REQ-011 cfg_ready SHALL be low while the addressed channel cfg_ch is in PEND, and high otherwise.
REQ-012 In OFF, the counter SHALL hold at 0, and tick_o and div_clk_o SHALL be 0.
REQ-013 cfg_ch >= NUM_CH SHALL be accepted and ignored.
REQ-014 sync_i=1 SHALL zero the counters of all enabled channels on the next cycle, and SHALL apply any pending shadow immediately.
REQ-015 When sync_i coincides with a transfer, the new config SHALL be applied immediately.
REQ-016 tick_o SHALL be suppressed in the cycle in which sync_i is asserted.

Reset
REQ-017 On rst_n low, asynchronously:
- all channels RUN with D=RST_DIV and counter=0
- shadows cleared
- tick_o=0, div_clk_o=0, cfg_ready=1
REQ-018 Reset asserted mid-period SHALL discard all pending updates. The first tick after release SHALL occur RST_DIV cycles after the first clk edge with rst_n high.

Configuration
REQ-019 With OSC_DIV_GEN_CLKOUT_EN defined, div_clk_o[n] SHALL be registered high while counter < ceil(D/2) and low otherwise (D=1 gives constant high in RUN).
REQ-020 Without OSC_DIV_GEN_CLKOUT_EN, div_clk_o SHALL be tied to 0 and the comparison logic SHALL not be built; tick behaviour SHALL be unchanged.

Structure
REQ-021 Package osc_div_pkg SHALL hold the channel state enum (OFF, RUN, PEND) and the default DIV_W and RST_DIV constants.
REQ-022 Per-channel counter, shadow and FSM SHALL be sub-module osc_div_ch, instantiated NUM_CH times by generate; osc_div_gen holds only config decode, cfg_ready mux and sync fan-out.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Reset release, no config -> tick_o[0..3] every 3 cycles, first tick on cycle 3.
- Write ch1 D=5 while running D=3 -> cfg_ready low until the ch1 tick; next ch1 period exactly 5; ch0/2/3 unchanged.
- Write ch2 D=0 -> tick_o[2] high every cycle; write cfg_en=0 -> ch2 OFF after its current wrap, outputs 0.
- Channels at D=4,6 with sync_i pulsed at arbitrary phase -> both counters 0 next cycle; ticks 4 and 6 cycles later; no tick in the sync cycle.
- sync_i with a simultaneous write ch3 D=7 -> ch3 period 7 immediately; rst_n pulsed mid-PEND -> D back to 3, cfg_ready=1.
- With OSC_DIV_GEN_CLKOUT_EN, D=5 -> div_clk_o high 3 cycles, low 2; without the macro -> div_clk_o constantly 0.

Source files
------------

// File: rtl/osc_div_pkg.sv
// Shared types and default constants for the oscillator divider generator.
package osc_div_pkg;

   localparam int unsigned DEF_DIV_W   = 16;
   localparam int unsigned DEF_RST_DIV = 3;

   // Per-channel operating state: stopped, running, running with a queued update.
   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } ch_state_e;

endpackage

// File: rtl/osc_div_ch.sv
// One divider channel: period counter, shadow config register and update FSM.
// Optional square-wave output built only when OSC_DIV_GEN_CLKOUT_EN is defined.
module osc_div_ch
   import osc_div_pkg::*;
#(
   parameter int unsigned DIV_W   = DEF_DIV_W,
   parameter int unsigned RST_DIV = DEF_RST_DIV
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_i,
   input  logic [DIV_W-1:0] wr_div_i,
   input  logic             wr_en_i,
   input  logic             sync_i,
   output logic             pend_o,
   output logic             tick_o,
   output logic             div_clk_o
);

   localparam int unsigned      HW      = DIV_W + 1;
   localparam logic [DIV_W-1:0] RST_EFF = (RST_DIV == 0) ? DIV_W'(1) : DIV_W'(RST_DIV);

   // A divide value of zero behaves as divide-by-one.
   function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
      return (d == '0) ? DIV_W'(1) : d;
   endfunction

   ch_state_e        state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] shd_div_q, shd_div_d;
   logic             shd_en_q, shd_en_d;
   logic             tick_q, tick_d;
   logic             wrap_c;
   logic             ld_c;
   logic [DIV_W-1:0] ld_div_c;
   logic             ld_en_c;

   assign wrap_c = (state_q != ST_OFF) && (cnt_q == (div_q - DIV_W'(1)));

   // Next-state: count, queue updates while running, apply them on wrap or sync.
   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      cnt_d     = cnt_q;
      shd_div_d = shd_div_q;
      shd_en_d  = shd_en_q;
      ld_c      = 1'b0;
      ld_div_c  = shd_div_q;
      ld_en_c   = shd_en_q;
      if (wr_i) begin
         shd_div_d = wr_div_i;
         shd_en_d  = wr_en_i;
      end
      case (state_q)
         ST_OFF: begin
            if (wr_i && wr_en_i) begin
               ld_c     = 1'b1;
               ld_div_c = wr_div_i;
               ld_en_c  = 1'b1;
            end
         end
         ST_RUN: begin
            cnt_d = wrap_c ? '0 : cnt_q + DIV_W'(1);
            if (sync_i) begin
               cnt_d = '0;
               if (wr_i) begin
                  ld_c     = 1'b1;
                  ld_div_c = wr_div_i;
                  ld_en_c  = wr_en_i;
               end
            end else if (wr_i) begin
               state_d = ST_PEND;
            end
         end
         ST_PEND: begin
            cnt_d = wrap_c ? '0 : cnt_q + DIV_W'(1);
            if (sync_i || wrap_c) begin
               ld_c = 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase
      if (ld_c) begin
         state_d = ld_en_c ? ST_RUN : ST_OFF;
         div_d   = eff_div(ld_div_c);
         cnt_d   = '0;
      end
      tick_d = wrap_c && !sync_i && (state_d != ST_OFF);
   end

   // Channel state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RUN;
         div_q     <= RST_EFF;
         cnt_q     <= '0;
         shd_div_q <= '0;
         shd_en_q  <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         cnt_q     <= cnt_d;
         shd_div_q <= shd_div_d;
         shd_en_q  <= shd_en_d;
         tick_q    <= tick_d;
      end
   end

   assign pend_o = (state_q == ST_PEND);
   assign tick_o = tick_q;

`ifdef OSC_DIV_GEN_CLKOUT_EN
   logic [HW-1:0] half_c;
   logic          dclk_q, dclk_d;

   assign half_c = ({1'b0, div_d} + HW'(1)) >> 1;
   assign dclk_d = (state_d != ST_OFF) && ({1'b0, cnt_d} < half_c);

   // Square wave: high for the first ceil(D/2) counts of each period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dclk_q <= 1'b0;
      end else begin
         dclk_q <= dclk_d;
      end
   end

   assign div_clk_o = dclk_q;
`else
   assign div_clk_o = 1'b0;
`endif

endmodule

// File: rtl/osc_div_gen.sv
// Multi-channel clock divider: config decode, ready mux and sync fan-out.
// Square-wave outputs are present only when OSC_DIV_GEN_CLKOUT_EN is defined.
module osc_div_gen
   import osc_div_pkg::*;
#(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned DIV_W   = DEF_DIV_W,
   parameter int unsigned RST_DIV = DEF_RST_DIV,
   localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic              cfg_en,
   input  logic              sync_i,
   output logic [NUM_CH-1:0] tick_o,
   output logic [NUM_CH-1:0] div_clk_o
);

   logic [NUM_CH-1:0] ch_pend;
   logic              xfer_c;

   // Back-pressure only when the addressed channel still holds a queued update.
   always_comb begin
      cfg_ready = 1'b1;
      for (int unsigned n = 0; n < NUM_CH; n++) begin
         if ((cfg_ch == CH_W'(n)) && ch_pend[n]) begin
            cfg_ready = 1'b0;
         end
      end
   end

   assign xfer_c = cfg_valid && cfg_ready;

   // One divider per channel; out-of-range channel writes reach no instance.
   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      osc_div_ch #(
         .DIV_W   (DIV_W),
         .RST_DIV (RST_DIV)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .wr_i      (xfer_c && (cfg_ch == CH_W'(n))),
         .wr_div_i  (cfg_div),
         .wr_en_i   (cfg_en),
         .sync_i    (sync_i),
         .pend_o    (ch_pend[n]),
         .tick_o    (tick_o[n]),
         .div_clk_o (div_clk_o[n])
      );
   end

endmodule
